// File: rtl/decode_stage_if.sv
// Decode-to-execute bus: decode-side instruction inputs, regfile read/writeback nets and registered E-stage outputs.
interface decode_stage_if #(parameter int XLEN = 32);
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic            valid_d;
  logic            stall_d;
  logic            flush_e;
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            valid_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] src_a_e;
  logic [XLEN-1:0] src_b_e;
  logic [XLEN-1:0] imm_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;
  logic [6:0]      opcode_e;
  logic [2:0]      funct3_e;
  logic            funct7b5_e;

  modport slave (
    input  instr_d, pc_d, valid_d, stall_d, flush_e, rd1, rd2, wb_we, wb_addr, wb_data,
    output ra1, ra2, valid_e, pc_e, src_a_e, src_b_e, imm_e, rs1_e, rs2_e, rd_e,
           opcode_e, funct3_e, funct7b5_e
  );

  modport master (
    output instr_d, pc_d, valid_d, stall_d, flush_e, rd1, rd2, wb_we, wb_addr, wb_data,
    input  ra1, ra2, valid_e, pc_e, src_a_e, src_b_e, imm_e, rs1_e, rs2_e, rd_e,
           opcode_e, funct3_e, funct7b5_e
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: immediate generation, operand select and the D/E pipeline register.
// Optional macro WB_BYPASS_EN forwards writeback data into the operands.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  d
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
  } e_regs_t;

  logic [31:0]     instr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  e_regs_t         e_d;
  e_regs_t         e_q;

  assign instr = d.instr_d;
  assign d.ra1 = instr[19:15];
  assign d.ra2 = instr[24:20];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{instr[31]}}, instr[31:20]};
      7'b0100011: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {instr[31:12], 12'b0};
      7'b1101111: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    opnd_a = d.rd1;
    opnd_b = d.rd2;
    if (d.wb_we && (d.wb_addr != 5'd0) && (d.wb_addr == d.ra1)) opnd_a = d.wb_data;
    if (d.wb_we && (d.wb_addr != 5'd0) && (d.wb_addr == d.ra2)) opnd_b = d.wb_data;
  end
`else
  // Without forwarding the hazard unit covers WB-to-D dependencies with a stall.
  logic unused_wb;
  assign unused_wb = ^{d.wb_we, d.wb_addr, d.wb_data};
  always_comb begin
    opnd_a = d.rd1;
    opnd_b = d.rd2;
  end
`endif

  // Flush wins over stall so a squashed instruction never lingers in E.
  always_comb begin
    e_d = e_q;
    if (d.flush_e) begin
      e_d = '0;
    end else if (!d.stall_d) begin
      e_d.valid    = d.valid_d;
      e_d.pc       = d.pc_d;
      e_d.src_a    = (d.ra1 == 5'd0) ? '0 : opnd_a;
      e_d.src_b    = (d.ra2 == 5'd0) ? '0 : opnd_b;
      e_d.imm      = imm;
      e_d.rs1      = d.ra1;
      e_d.rs2      = d.ra2;
      e_d.rd       = instr[11:7];
      e_d.opcode   = instr[6:0];
      e_d.funct3   = instr[14:12];
      e_d.funct7b5 = instr[30];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  assign d.valid_e    = e_q.valid;
  assign d.pc_e       = e_q.pc;
  assign d.src_a_e    = e_q.src_a;
  assign d.src_b_e    = e_q.src_b;
  assign d.imm_e      = e_q.imm;
  assign d.rs1_e      = e_q.rs1;
  assign d.rs2_e      = e_q.rs2;
  assign d.rd_e       = e_q.rd;
  assign d.opcode_e   = e_q.opcode;
  assign d.funct3_e   = e_q.funct3;
  assign d.funct7b5_e = e_q.funct7b5;

endmodule
